alu_share_ctrl: RTL
===================

Name: alu_share_ctrl

Overview:
- Sequencer and arbiter that shares the single combinational 16-bit ALU between two requesters.
- Accepts operations over valid/ready handshakes and drives the ALU's data1/data2/op inputs from registers.
- Waits a fixed settle time, then captures upper/lower/zero.
- Returns the result with a requester ID over a response handshake. Sits between the register-file read stage and the ALU.

Parameters:
- WIDTH, 16, ALU operand and result-half width.
- OPW, 4, ALU opcode width.
- SETTLE, 1, cycles the operands are held on the ALU before capture (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand 1
- req0_b  input  WIDTH  requester 0 operand 2
- req0_op  input  OPW  requester 0 ALU opcode
- req1_valid/req1_ready/req1_a/req1_b/req1_op  as above, requester 1
- alu_dat1  output  WIDTH  to ALU data1
- alu_dat2  output  WIDTH  to ALU data2
- alu_op  output  OPW  to ALU op
- alu_upper  input  WIDTH  ALU upper result
- alu_lower  input  WIDTH  ALU lower result
- alu_zero  input  1  ALU zero flag
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that issued the result
- rsp_upper  output  WIDTH  captured upper
- rsp_lower  output  WIDTH  captured lower
- rsp_zero  output  1  captured zero
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, including alu_dat1/alu_dat2/alu_op, rsp_* and req*_ready.
  - Round-robin pointer = 0, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid is high, grant one. A single requester wins outright. If both are high, the requester other than the last granted wins.
  - On grant:
    - reqN_ready=1 for exactly that cycle, combinational from state and valid.
    - Operands and op latch into the alu_* registers at the clock edge.
    - Settle counter loads SETTLE-1; grant ID is latched; round-robin pointer is updated.
    - Next state EXEC.
  - With no valid: stay in IDLE, alu_* hold their last values.
- EXEC:
  - alu_* stay stable.
  - Counter decrements each cycle. At counter==0, alu_upper/alu_lower/alu_zero are captured into rsp_* registers, rsp_valid is set, and the state moves to RESP.
  - With SETTLE=1, EXEC lasts exactly one cycle.
- RESP:
  - rsp_valid=1; rsp_* and rsp_id are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid clears at the edge, next state IDLE. rsp_* data holds its value.
- Req ready is never asserted outside IDLE, so only one operation is ever outstanding.
- Back-to-back throughput: SETTLE+2 cycles per operation when rsp_ready is held high.
- Latency: grant edge to rsp_valid = SETTLE cycles.
- A request that drops valid before it is granted is ignored; no state change.
- Simultaneous valids with the pointer at requester 1 grant requester 1.
- Reset asserted mid-EXEC or mid-RESP aborts the operation: no response is issued and the pointer returns to 0.
- The ALU result is never sampled before the counter expires. X on the ALU outputs before capture must not propagate to rsp_*.
- No arithmetic is done in this block. The captured value is exactly the ALU output, width WIDTH per half.

Optional Feature:
- Macro: ALU_SHARE_STATS_EN.
- When defined:
  - Adds outputs cnt0 and cnt1, 16 bits each.
  - Each counts responses completed (rsp handshake) for its requester.
  - Counters wrap modulo 2^16 and reset to 0 asynchronously.
  - Adds input stats_clr (1 bit). stats_clr synchronously zeroes both counters and takes priority over an increment in the same cycle.
- When undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package alu_share_pkg holds:
  - State encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
  - Opcode constants OP_ADD=4'h0 and OP_SUB=4'h1.
  - Requester ID constants.
- One natural sub-module: rr_arb2, the 2-way round-robin arbiter (valid pair plus pointer in, one-hot grant out, pointer update). The FSM, operand registers and capture stay in the top.

Test Plan:
- ADD: req0 a=000F, b=0001, op=0, SETTLE=1, rsp_ready=1 -> req0_ready pulses once; rsp_valid appears 1 cycle after grant with rsp_lower=0010, rsp_upper=0000, rsp_zero=0, rsp_id=0.
- SUB: req1 a=0A00, b=00F0, op=1 -> rsp_lower=0910, rsp_zero=0, rsp_id=1.
- Zero flag: ADD 0000+0000 -> rsp_zero=1. Tie: both valid held for 4 operations -> grant order 0,1,0,1; each rsp_id matches.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req0_ready and req1_ready stay 0, busy=1; rsp_ready=1 -> IDLE next cycle.
- SETTLE=3: alu_dat1/alu_dat2/alu_op stable for 3 cycles and rsp_valid rises on the 3rd edge after grant. Drive alu outputs to X until cycle 2 -> rsp_* remain known.
- Reset during EXEC: rst_n=0 for 1 cycle -> all outputs 0 immediately, no rsp_valid afterwards, next tie grants req0. With ALU_SHARE_STATS_EN: 3 req0 completions -> cnt0=3; stats_clr -> cnt0=0.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared constants for the ALU-sharing sequencer: FSM state encoding, opcodes, requester IDs.
package alu_share_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  // Settle counter width; covers SETTLE up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_EXEC = ST_EXEC,
    S_RESP = ST_RESP
  } state_e;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: ptr names the requester that wins a tie.
module rr_arb2
  import alu_share_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  always_comb begin
    gnt     = valid;
    ptr_nxt = ptr;
    if (valid == 2'b11) begin
      gnt = (ptr == ID_REQ1) ? 2'b10 : 2'b01;
    end
    // After a grant, the other requester takes priority for the next tie.
    if (gnt[0]) begin
      ptr_nxt = ID_REQ1;
    end else if (gnt[1]) begin
      ptr_nxt = ID_REQ0;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequencer/arbiter sharing one combinational ALU between two requesters.
// Optional per-requester completion counters when ALU_SHARE_STATS_EN is defined.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int OPW    = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_dat1,
  output logic [WIDTH-1:0] alu_dat2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_upper,
  input  logic [WIDTH-1:0] alu_lower,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_upper,
  output logic [WIDTH-1:0] rsp_lower,
  output logic             rsp_zero,
  output logic             busy
`ifdef ALU_SHARE_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

  state_e           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             ptr;
  logic             ptr_nxt;
  logic             gnt_id;
  logic [1:0]       req_vld;
  logic [1:0]       gnt;

  // Only IDLE may grant, which keeps a single operation outstanding.
  assign req_vld = {req1_valid, req0_valid} & {2{state == S_IDLE}};

  rr_arb2 u_arb (
    .valid   (req_vld),
    .ptr     (ptr),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );

  assign req0_ready = rst_n & gnt[0];
  assign req1_ready = rst_n & gnt[1];
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      ptr        <= ID_REQ0;
      gnt_id     <= ID_REQ0;
      alu_dat1   <= '0;
      alu_dat2   <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_upper  <= '0;
      rsp_lower  <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|gnt) begin
            alu_dat1   <= gnt[1] ? req1_a  : req0_a;
            alu_dat2   <= gnt[1] ? req1_b  : req0_b;
            alu_op     <= gnt[1] ? req1_op : req0_op;
            settle_cnt <= SETTLE_LD;
            gnt_id     <= gnt[1];
            ptr        <= ptr_nxt;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          // ALU outputs are only looked at once the settle time has elapsed.
          if (settle_cnt == '0) begin
            rsp_upper <= alu_upper;
            rsp_lower <= alu_lower;
            rsp_zero  <= alu_zero;
            rsp_id    <= gnt_id;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SHARE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (stats_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_id == ID_REQ1) begin
        cnt1 <= cnt1 + 16'd1;
      end else begin
        cnt0 <= cnt0 + 16'd1;
      end
    end
  end
`endif

endmodule
